// File: rtl/multi_dataflow_tcdm_bridge.sv
// Per-channel request FIFO plus outstanding-request limiter between the accelerator's TCDM ports
// and the cluster interconnect. Define MULTI_DATAFLOW_BRIDGE_PERF_EN to add per-channel stall counters.
module multi_dataflow_tcdm_bridge #(
  parameter int MP      = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 2,
  localparam int BW     = DW / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [MP-1:0]    acc_req,
  output logic [MP-1:0]    acc_gnt,
  input  logic [MP*AW-1:0] acc_add,
  input  logic [MP-1:0]    acc_wen,
  input  logic [MP*BW-1:0] acc_be,
  input  logic [MP*DW-1:0] acc_data,
  output logic [MP*DW-1:0] acc_r_data,
  output logic [MP-1:0]    acc_r_valid,
  output logic [MP-1:0]    tcdm_req,
  input  logic [MP-1:0]    tcdm_gnt,
  output logic [MP*AW-1:0] tcdm_add,
  output logic [MP-1:0]    tcdm_wen,
  output logic [MP*BW-1:0] tcdm_be,
  output logic [MP*DW-1:0] tcdm_data,
  input  logic [MP*DW-1:0] tcdm_r_data,
  input  logic [MP-1:0]    tcdm_r_valid,
  output logic [MP-1:0]    err_o,
  output logic             busy_o
`ifdef MULTI_DATAFLOW_BRIDGE_PERF_EN
  ,
  output logic [MP*32-1:0] perf_stall_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int EW = AW + 1 + BW + DW;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  logic [MP-1:0] busy_ch;

  // Responses are forwarded untouched, including spurious ones.
  assign acc_r_valid = tcdm_r_valid;
  assign acc_r_data  = tcdm_r_data;
  assign busy_o      = |busy_ch;

  genvar gi;
  generate
    for (gi = 0; gi < MP; gi++) begin : g_ch
      logic [EW-1:0] mem [DEPTH];
      logic [EW-1:0] head;
      logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0] count_reg, count_next;
      logic [OW-1:0] out_cnt_reg, out_cnt_next;
      logic          err_reg, err_next;
      logic          gnt, req, push, pop, rvalid;

      assign gnt    = count_reg < DEPTH_C;
      assign req    = (count_reg != '0) && (out_cnt_reg < MAX_OUT_C);
      assign push   = acc_req[gi] & gnt;
      assign pop    = req & tcdm_gnt[gi];
      assign rvalid = tcdm_r_valid[gi];

      always_comb begin
        count_next   = count_reg;
        out_cnt_next = out_cnt_reg;
        err_next     = err_reg;
        case ({push, pop})
          2'b10:   count_next = count_reg + CW'(1);
          2'b01:   count_next = count_reg - CW'(1);
          default: count_next = count_reg;
        endcase
        // A pop coinciding with a response leaves the outstanding count as is.
        if (pop && !rvalid)
          out_cnt_next = out_cnt_reg + OW'(1);
        else if (rvalid && !pop && out_cnt_reg != '0)
          out_cnt_next = out_cnt_reg - OW'(1);
        if (rvalid && out_cnt_reg == '0)
          err_next = 1'b1;
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
          wr_ptr_reg  <= '0;
          rd_ptr_reg  <= '0;
          count_reg   <= '0;
          out_cnt_reg <= '0;
          err_reg     <= 1'b0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          count_reg   <= count_next;
          out_cnt_reg <= out_cnt_next;
          err_reg     <= err_next;
        end
      end

      // Storage is not reset; the head is don't-care while tcdm_req is low.
      always_ff @(posedge clk_i) begin
        if (push)
          mem[wr_ptr_reg] <= {acc_add[gi*AW +: AW], acc_wen[gi], acc_be[gi*BW +: BW],
                              acc_data[gi*DW +: DW]};
      end

      assign head = mem[rd_ptr_reg];
      assign {tcdm_add[gi*AW +: AW], tcdm_wen[gi], tcdm_be[gi*BW +: BW],
              tcdm_data[gi*DW +: DW]} = head;

      assign acc_gnt[gi]  = gnt;
      assign tcdm_req[gi] = req;
      assign err_o[gi]    = err_reg;
      assign busy_ch[gi]  = (count_reg != '0) || (out_cnt_reg != '0);

`ifdef MULTI_DATAFLOW_BRIDGE_PERF_EN
      logic [31:0] stall_reg;
      always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i)
          stall_reg <= '0;
        else if (req && !tcdm_gnt[gi] && stall_reg != 32'hFFFF_FFFF)
          stall_reg <= stall_reg + 32'd1;
      end
      assign perf_stall_o[gi*32 +: 32] = stall_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_multi_dataflow_tcdm_bridge.sv
// Directed plus randomized bench for multi_dataflow_tcdm_bridge against a queue-based channel model.
module tb_multi_dataflow_tcdm_bridge;
  localparam int MP = 4, DW = 32, AW = 32, DEPTH = 2, MAX_OUT = 2, BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_ni, clear_i;
  logic [MP-1:0]    acc_req, acc_gnt, acc_wen, acc_r_valid;
  logic [MP*AW-1:0] acc_add, tcdm_add;
  logic [MP*BW-1:0] acc_be, tcdm_be;
  logic [MP*DW-1:0] acc_data, acc_r_data, tcdm_data, tcdm_r_data;
  logic [MP-1:0]    tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, err_o;
  logic             busy_o;
`ifdef MULTI_DATAFLOW_BRIDGE_PERF_EN
  logic [MP*32-1:0] perf_stall_o;
`endif

  always #5 clk = ~clk;

  multi_dataflow_tcdm_bridge #(.MP(MP), .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .acc_req(acc_req), .acc_gnt(acc_gnt), .acc_add(acc_add), .acc_wen(acc_wen),
    .acc_be(acc_be), .acc_data(acc_data), .acc_r_data(acc_r_data), .acc_r_valid(acc_r_valid),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid), .err_o(err_o), .busy_o(busy_o)
`ifdef MULTI_DATAFLOW_BRIDGE_PERF_EN
    , .perf_stall_o(perf_stall_o)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } req_t;

  // Reference model: each channel is a bounded queue of pending requests,
  // a count of granted-but-unanswered requests, a sticky error and a stall count.
  req_t        mq [MP][$];
  int          mout [MP];
  bit          merr [MP];
  logic [31:0] mstall [MP];
  int          checks = 0, failures = 0;
  bit          checking = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_gnt(int ch);
    return mq[ch].size() < DEPTH;
  endfunction

  function automatic bit exp_req(int ch);
    return (mq[ch].size() != 0) && (mout[ch] < MAX_OUT);
  endfunction

  task automatic check_all();
    bit busy_e = 0;
    for (int ch = 0; ch < MP; ch++) begin
      chk($sformatf("acc_gnt[%0d]", ch), 64'(acc_gnt[ch]), 64'(exp_gnt(ch)));
      chk($sformatf("tcdm_req[%0d]", ch), 64'(tcdm_req[ch]), 64'(exp_req(ch)));
      if (exp_req(ch)) begin
        chk($sformatf("tcdm_add[%0d]", ch), 64'(tcdm_add[ch*AW +: AW]), 64'(mq[ch][0].add));
        chk($sformatf("tcdm_wen[%0d]", ch), 64'(tcdm_wen[ch]), 64'(mq[ch][0].wen));
        chk($sformatf("tcdm_be[%0d]", ch), 64'(tcdm_be[ch*BW +: BW]), 64'(mq[ch][0].be));
        chk($sformatf("tcdm_data[%0d]", ch), 64'(tcdm_data[ch*DW +: DW]), 64'(mq[ch][0].data));
      end
      chk($sformatf("err_o[%0d]", ch), 64'(err_o[ch]), 64'(merr[ch]));
      chk($sformatf("acc_r_valid[%0d]", ch), 64'(acc_r_valid[ch]), 64'(tcdm_r_valid[ch]));
      chk($sformatf("acc_r_data[%0d]", ch), 64'(acc_r_data[ch*DW +: DW]),
          64'(tcdm_r_data[ch*DW +: DW]));
`ifdef MULTI_DATAFLOW_BRIDGE_PERF_EN
      chk($sformatf("perf_stall[%0d]", ch), 64'(perf_stall_o[ch*32 +: 32]), 64'(mstall[ch]));
`endif
      if (mq[ch].size() != 0 || mout[ch] != 0) busy_e = 1;
    end
    chk("busy_o", 64'(busy_o), 64'(busy_e));
  endtask

  // Advance the model by the clock edge about to happen, using the inputs as driven now.
  task automatic model_step();
    for (int ch = 0; ch < MP; ch++) begin
      bit push, pop, rv;
      if (!rst_ni || clear_i) begin
        mq[ch].delete();
        mout[ch] = 0; merr[ch] = 0; mstall[ch] = '0;
        continue;
      end
      push = acc_req[ch] && exp_gnt(ch);
      pop  = exp_req(ch) && tcdm_gnt[ch];
      rv   = tcdm_r_valid[ch];
      if (exp_req(ch) && !tcdm_gnt[ch] && mstall[ch] != 32'hFFFF_FFFF) mstall[ch]++;
      if (rv && mout[ch] == 0) merr[ch] = 1;
      if (pop && !rv) mout[ch]++;
      else if (rv && !pop && mout[ch] > 0) mout[ch]--;
      if (pop) void'(mq[ch].pop_front());
      if (push) mq[ch].push_back('{acc_add[ch*AW +: AW], acc_wen[ch], acc_be[ch*BW +: BW],
                                   acc_data[ch*DW +: DW]});
    end
  endtask

  task automatic settle();
    #2;
    if (checking) check_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic set_req(int ch, logic [AW-1:0] add, logic wen, logic [BW-1:0] be, logic [DW-1:0] data);
    acc_req[ch] = 1'b1;
    acc_add[ch*AW +: AW] = add;
    acc_wen[ch] = wen;
    acc_be[ch*BW +: BW] = be;
    acc_data[ch*DW +: DW] = data;
  endtask

  task automatic rand_req(int ch);
    set_req(ch, $urandom, 1'($urandom_range(0, 1)), BW'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0;
    acc_req = '0; acc_add = '0; acc_wen = '0; acc_be = '0; acc_data = '0;
    tcdm_gnt = '0; tcdm_r_data = '0; tcdm_r_valid = '0;
    @(posedge clk); #1;
    tick(); tick();
    rst_ni = 1'b1;
    checking = 1;

    // Reset state
    settle();
    chk("reset acc_gnt", 64'(acc_gnt), 64'hF);
    chk("reset tcdm_req", 64'(tcdm_req), 64'h0);
    chk("reset busy", 64'(busy_o), 64'h0);
    chk("reset err", 64'(err_o), 64'h0);
    advance();

    // Single read on ch0
    tcdm_gnt = '1;
    set_req(0, 32'h100, 1'b1, 4'hF, 32'h0);
    tick();
    acc_req = '0;
    settle();
    chk("single tcdm_req0", 64'(tcdm_req[0]), 64'h1);
    chk("single tcdm_add0", 64'(tcdm_add[31:0]), 64'h100);
    advance();
    tcdm_r_valid[0] = 1'b1; tcdm_r_data[31:0] = 32'hDEAD_BEEF;
    settle();
    chk("single r_data", 64'(acc_r_data[31:0]), 64'hDEAD_BEEF);
    advance();
    tcdm_r_valid = '0;
    settle();
    chk("single busy idle", 64'(busy_o), 64'h0);
    advance();

    // Backpressure on ch2
    tcdm_gnt = '0;
    for (int i = 0; i < 3; i++) begin
      rand_req(2);
      settle();
      if (i == 2) chk("bp gnt dropped", 64'(acc_gnt[2]), 64'h0);
      advance();
    end
    acc_req = '0;
    repeat (3) tick();
    tcdm_gnt = '1;
    repeat (3) tick();
    tcdm_r_valid[2] = 1'b1;
    repeat (2) tick();
    tcdm_r_valid = '0;
    settle();
    chk("bp idle", 64'(busy_o), 64'h0);
    advance();

    // Outstanding limit on ch3
    for (int i = 0; i < 3; i++) begin
      rand_req(3);
      tick();
    end
    acc_req = '0;
    settle();
    chk("limit req low", 64'(tcdm_req[3]), 64'h0);
    chk("limit busy", 64'(busy_o), 64'h1);
    advance();
    tcdm_r_valid[3] = 1'b1;
    tick();
    tcdm_r_valid = '0;
    settle();
    chk("limit third req", 64'(tcdm_req[3]), 64'h1);
    advance();
    tcdm_r_valid[3] = 1'b1;
    repeat (2) tick();
    tcdm_r_valid = '0;

    // Pop and response together on ch0 with one outstanding
    rand_req(0); tick();
    rand_req(0); tick();
    acc_req = '0; tcdm_r_valid[0] = 1'b1;
    tick();
    tcdm_r_valid = '0;
    settle();
    chk("simul err0", 64'(err_o[0]), 64'h0);
    chk("simul busy", 64'(busy_o), 64'h1);
    advance();
    tcdm_r_valid[0] = 1'b1;
    tick();
    tcdm_r_valid = '0;

    // Spurious response on ch1, then soft clear
    tcdm_r_valid[1] = 1'b1; tcdm_r_data[63:32] = 32'h1234_5678;
    tick();
    tcdm_r_valid = '0;
    repeat (2) begin
      settle();
      chk("spurious err", 64'(err_o), 64'h2);
      advance();
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    settle();
    chk("clear err", 64'(err_o), 64'h0);
    advance();

    // Reset with two queued and one outstanding on ch0
    rand_req(0); tick();
    rand_req(0); tick();
    tcdm_gnt = '0;
    rand_req(0); tick();
    acc_req = '0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1; tcdm_gnt = '1;
    settle();
    chk("rst tcdm_req", 64'(tcdm_req), 64'h0);
    chk("rst acc_gnt", 64'(acc_gnt), 64'hF);
    chk("rst busy", 64'(busy_o), 64'h0);
    advance();

    // Randomized traffic on all channels
    for (int n = 0; n < 400; n++) begin
      acc_req = '0;
      for (int ch = 0; ch < MP; ch++) begin
        if ($urandom_range(0, 2) != 0) rand_req(ch);
        tcdm_gnt[ch] = ($urandom_range(0, 3) != 0);
        tcdm_r_valid[ch] = (mout[ch] > 0) && ($urandom_range(0, 1) == 1);
        tcdm_r_data[ch*DW +: DW] = $urandom;
      end
      tick();
    end

    // Drain with a bounded cycle budget
    acc_req = '0; tcdm_gnt = '1;
    for (int n = 0; n < 50; n++) begin
      for (int ch = 0; ch < MP; ch++) tcdm_r_valid[ch] = (mout[ch] > 0);
      tick();
    end
    tcdm_r_valid = '0;
    settle();
    chk("drain busy", 64'(busy_o), 64'h0);
    chk("drain err", 64'(err_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
